gshare_btb_predictor: RTL and testbench
=======================================

GSHARE_BTB_PREDICTOR -- requirements
Module: gshare_btb_predictor

Interface
REQ-001 Parameter ENTRIES, 32, BTB/PHT depth; power of two, 4..1024.
REQ-002 Parameter GHR_BITS, 5, global history length; 1..log2(ENTRIES); violation is an elaboration error.
REQ-003 Parameter CTR_BITS, 2, PHT saturating-counter width; 2..4.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 if_pc  in  32  fetch-stage PC to look up.
REQ-007 if_advance  in  1  fetch accepted this cycle (pcwrite); low = stall, no history change.
REQ-008 upd_valid  in  1  EX-stage resolved branch present.
REQ-009 upd_pc  in  32  PC of resolved branch.
REQ-010 upd_taken  in  1  resolved direction.
REQ-011 upd_target  in  32  resolved target address.
REQ-012 upd_ghr  in  GHR_BITS  history snapshot carried from that branch's prediction.
REQ-013 upd_mispredict  in  1  direction or target mispredicted; qualifies with upd_valid.
REQ-014 pred_hit  out  1  BTB valid and tag match for if_pc.
REQ-015 pred_taken  out  1  predicted taken.
REQ-016 pred_target  out  32  next fetch PC.
REQ-017 pred_ghr  out  GHR_BITS  history used for this prediction, to be piped to EX.

Function
REQ-018 IDX = log2(ENTRIES); index = if_pc[IDX+1:2]; tag = if_pc[31:IDX+2]; same split for upd_pc.
REQ-019 BTB (valid, tag, target) indexed by plain index; PHT indexed by index XOR zero-extended GHR.
REQ-020 Lookup combinational, zero latency: pred_hit = valid & tag match; pred_taken = pred_hit & counter MSB; pred_target = BTB target if pred_taken else if_pc+4 (mod 2^32); pred_ghr = current GHR.
REQ-021 Update on upd_valid: PHT[upd index XOR upd_ghr] saturating +1 if taken, -1 if not; no wrap at 0 or 2^CTR_BITS-1.
REQ-022 Taken update also writes BTB[upd index] = {1, upd tag, upd_target}; not-taken leaves BTB entry unchanged.
REQ-023 Speculative GHR: on if_advance & pred_hit & ~(upd_valid & upd_mispredict), GHR <= {GHR[GHR_BITS-2:0], pred_taken}; GHR_BITS=1 loads pred_taken.
REQ-024 Repair: on upd_valid & upd_mispredict, GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}; repair overrides any speculative shift that cycle.
REQ-025 Lookup and update to the same entry in one cycle: lookup returns pre-update contents; new contents visible next cycle.
REQ-026 if_advance low: outputs still driven from if_pc, no state change except update/repair.

Reset
REQ-027 Asserted reset immediately clears all BTB valid bits, GHR to 0, all PHT counters to 2^(CTR_BITS-1)-1 (weakly not-taken), regardless of clock.
REQ-028 During reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4, pred_ghr=0; updates ignored.
REQ-029 Reset mid-operation discards in-flight state; first post-reset edge behaves as from cold.

Configuration
REQ-030 Macro BP_PERF_CNT_EN defined: adds outputs perf_lookups (32) and perf_mispredicts (32); perf_lookups increments on if_advance, perf_mispredicts on upd_valid & upd_mispredict; both wrap at 2^32, reset to 0.
REQ-031 Macro undefined: those ports and counters are absent; all other behaviour identical.

Structure
REQ-032 Package bp_pkg holds counter reset/threshold constants, saturating inc/dec functions, and the BTB entry typedef.
REQ-033 PHT is the sub-module bp_pht (read port, update port, reset init); BTB and GHR stay in the top.

Verification
REQ-034 After reset, if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, pred_ghr=0.
REQ-035 Two taken updates at 0x100 target 0x200, upd_ghr=0, GHR held 0 -> lookup 0x100 gives hit=1, taken=1, target=0x200.
REQ-036 Four not-taken updates on one PHT entry -> counter pinned at 0, no wrap; four taken -> pinned at 3 (CTR_BITS=2).
REQ-037 GHR=0b10110, same-cycle if_advance with predicted taken plus mispredict upd_ghr=0b00011, upd_taken=0 -> next GHR=0b00110.
REQ-038 Same-cycle lookup/update at 0x140 with empty entry -> lookup hit=0 that cycle, hit=1 next cycle.
REQ-039 With BP_PERF_CNT_EN: 10 if_advance cycles, 3 mispredicts -> perf_lookups=10, perf_mispredicts=3; reset mid-run -> both 0 immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare/BTB branch predictor.
// Counters are stored at the widest supported width; the active width is passed in.
package bp_pkg;

  localparam int unsigned CTR_MAX_BITS = 4;
  // ENTRIES >= 4 leaves at most 28 tag bits above the index and byte offset.
  localparam int unsigned TAG_MAX_BITS = 28;

  typedef logic [CTR_MAX_BITS-1:0] ctr_t;

  typedef struct packed {
    logic                    valid;
    logic [TAG_MAX_BITS-1:0] tag;
    logic [31:0]             target;
  } btb_entry_t;

  // Weakly not-taken: one below the taken threshold.
  function automatic ctr_t ctr_init(int unsigned w);
    return ctr_t'((32'd1 << (w - 32'd1)) - 32'd1);
  endfunction

  // Counter values at or above this predict taken.
  function automatic ctr_t ctr_thresh(int unsigned w);
    return ctr_t'(32'd1 << (w - 32'd1));
  endfunction

  function automatic ctr_t ctr_max(int unsigned w);
    return ctr_t'((32'd1 << w) - 32'd1);
  endfunction

  function automatic ctr_t ctr_inc(ctr_t c, int unsigned w);
    return (c >= ctr_max(w)) ? c : c + ctr_t'(1);
  endfunction

  function automatic ctr_t ctr_dec(ctr_t c);
    return (c == '0) ? c : c - ctr_t'(1);
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: one saturating counter per entry, combinational read,
// single update port, asynchronous reset to weakly not-taken.
module bp_pht
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = 32,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned IDX_BITS = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_taken,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  ctr_t ctr_q [ENTRIES];
  ctr_t ctr_d [ENTRIES];

  // Read returns pre-update contents; a same-cycle update shows up next cycle.
  assign rd_taken = (ctr_q[rd_idx] >= ctr_thresh(CTR_BITS));

  // Saturating step of the addressed counter.
  always_comb begin
    ctr_d = ctr_q;
    if (upd_en) begin
      ctr_d[upd_idx] = upd_taken ? ctr_inc(ctr_q[upd_idx], CTR_BITS)
                                 : ctr_dec(ctr_q[upd_idx]);
    end
  end

  // Counter storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= ctr_init(CTR_BITS);
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor with a direct-mapped BTB and speculative global history.
// Optional performance counters are enabled by defining BP_PERF_CNT_EN.
module gshare_btb_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = 32,
  parameter int unsigned GHR_BITS = 5,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         if_pc,
  input  logic                if_advance,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_mispredict,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [GHR_BITS-1:0] pred_ghr
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]         perf_lookups,
  output logic [31:0]         perf_mispredicts
`endif
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX;

  if (ENTRIES < 4 || ENTRIES > 1024 || (ENTRIES & (ENTRIES - 1)) != 32'd0) begin : g_bad_entries
    $error("ENTRIES must be a power of two in 4..1024");
  end
  if (GHR_BITS < 1 || GHR_BITS > IDX) begin : g_bad_ghr
    $error("GHR_BITS must be in 1..log2(ENTRIES)");
  end
  if (CTR_BITS < 2 || CTR_BITS > CTR_MAX_BITS) begin : g_bad_ctr
    $error("CTR_BITS must be in 2..4");
  end

  logic [IDX-1:0]      lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic [IDX-1:0]      upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  btb_entry_t          lk_entry;
  btb_entry_t          btb_q [ENTRIES];
  btb_entry_t          btb_d [ENTRIES];
  logic [GHR_BITS-1:0] ghr_q;
  logic [GHR_BITS-1:0] ghr_d;
  logic                pht_taken;
  logic                repair;
  logic                unused_pc_bits;

  assign lk_idx         = if_pc[IDX+1:2];
  assign lk_tag         = if_pc[31:IDX+2];
  assign upd_idx        = upd_pc[IDX+1:2];
  assign upd_tag        = upd_pc[31:IDX+2];
  assign repair         = upd_valid & upd_mispredict;
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  bp_pht #(
    .ENTRIES  (ENTRIES),
    .CTR_BITS (CTR_BITS),
    .IDX_BITS (IDX)
  ) u_pht (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (lk_idx ^ IDX'(ghr_q)),
    .rd_taken  (pht_taken),
    .upd_en    (upd_valid & ~reset),
    .upd_idx   (upd_idx ^ IDX'(upd_ghr)),
    .upd_taken (upd_taken)
  );

  // Zero-latency lookup; reset forces a miss so fall-through is if_pc + 4.
  always_comb begin
    lk_entry    = btb_q[lk_idx];
    pred_hit    = ~reset & lk_entry.valid & (lk_entry.tag == TAG_MAX_BITS'(lk_tag));
    pred_taken  = pred_hit & pht_taken;
    pred_target = pred_taken ? lk_entry.target : (if_pc + 32'd4);
    pred_ghr    = ghr_q;
  end

  // Only taken branches allocate or refresh a BTB entry.
  always_comb begin
    btb_d = btb_q;
    if (upd_valid && upd_taken) begin
      btb_d[upd_idx] = '{valid: 1'b1, tag: TAG_MAX_BITS'(upd_tag), target: upd_target};
    end
  end

  // History: repair from the resolved branch wins over this cycle's speculative shift.
  // The width cast drops the oldest bit, which also covers GHR_BITS == 1.
  always_comb begin
    ghr_d = ghr_q;
    if (repair) begin
      ghr_d = GHR_BITS'({upd_ghr, upd_taken});
    end else if (if_advance && pred_hit) begin
      ghr_d = GHR_BITS'({ghr_q, pred_taken});
    end
  end

  // BTB and history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
      end
    end else begin
      ghr_q <= ghr_d;
      btb_q <= btb_d;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_lookups_q;
  logic [31:0] perf_lookups_d;
  logic [31:0] perf_mispredicts_q;
  logic [31:0] perf_mispredicts_d;

  // Free-running event counters, wrapping at 2^32.
  always_comb begin
    perf_lookups_d     = perf_lookups_q + {31'd0, if_advance};
    perf_mispredicts_d = perf_mispredicts_q + {31'd0, repair};
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lookups_q     <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_lookups_q     <= perf_lookups_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_lookups     = perf_lookups_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Self-checking bench for gshare_btb_predictor: directed vector table, hand sequences
// for history repair and reset, then random traffic against an array-based model.
module tb_gshare_btb_predictor;

  localparam int unsigned ENTRIES  = 32;
  localparam int unsigned GHR_BITS = 5;
  localparam int unsigned CTR_BITS = 2;
  localparam int unsigned IDX      = $clog2(ENTRIES);
  localparam int unsigned CTR_TOP  = (1 << CTR_BITS) - 1;
  localparam int unsigned CTR_MID  = 1 << (CTR_BITS - 1);

  logic                clk = 1'b0;
  logic                reset;
  logic [31:0]         if_pc;
  logic                if_advance;
  logic                upd_valid;
  logic [31:0]         upd_pc;
  logic                upd_taken;
  logic [31:0]         upd_target;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                upd_mispredict;
  logic                pred_hit;
  logic                pred_taken;
  logic [31:0]         pred_target;
  logic [GHR_BITS-1:0] pred_ghr;
`ifdef BP_PERF_CNT_EN
  logic [31:0]         perf_lookups;
  logic [31:0]         perf_mispredicts;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gshare_btb_predictor #(
    .ENTRIES  (ENTRIES),
    .GHR_BITS (GHR_BITS),
    .CTR_BITS (CTR_BITS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .if_advance     (if_advance),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_ghr        (upd_ghr),
    .upd_mispredict (upd_mispredict),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_ghr       (pred_ghr)
`ifdef BP_PERF_CNT_EN
    ,
    .perf_lookups     (perf_lookups),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  typedef struct {
    logic [31:0]         pc;
    logic                adv;
    logic                uv;
    logic [31:0]         upc;
    logic                ut;
    logic [31:0]         utgt;
    logic [GHR_BITS-1:0] ughr;
    logic                um;
    logic                eh;
    logic                et;
    logic [31:0]         etgt;
    logic [GHR_BITS-1:0] eghr;
  } vec_t;

  function automatic vec_t mk(logic [31:0] pc, logic adv, logic uv, logic [31:0] upc,
                              logic ut, logic [31:0] utgt, logic [GHR_BITS-1:0] ughr,
                              logic um, logic eh, logic et, logic [31:0] etgt,
                              logic [GHR_BITS-1:0] eghr);
    vec_t v;
    v.pc = pc; v.adv = adv; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.ughr = ughr; v.um = um; v.eh = eh; v.et = et; v.etgt = etgt; v.eghr = eghr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_pc = v.pc; if_advance = v.adv; upd_valid = v.uv; upd_pc = v.upc;
    upd_taken = v.ut; upd_target = v.utgt; upd_ghr = v.ughr; upd_mispredict = v.um;
  endtask

  // Drive a vector after the falling edge, check the combinational lookup before the rising edge.
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    #1;
    check(name, 64'({pred_hit, pred_taken, pred_target, pred_ghr}),
          64'({v.eh, v.et, v.etgt, v.eghr}));
  endtask

  task automatic idle_inputs();
    if_pc = 32'h0; if_advance = 1'b0; upd_valid = 1'b0; upd_pc = 32'h0;
    upd_taken = 1'b0; upd_target = 32'h0; upd_ghr = '0; upd_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int unsigned m_pht   [ENTRIES];
  int unsigned m_ghr;

  function automatic int unsigned idx_of(logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_pht[i] = CTR_MID - 1;
    end
    m_ghr = 0;
  endfunction

  task automatic run_random(input int cycles);
    logic        eh, et;
    logic [31:0] etgt;
    int unsigned li, ui, pi;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if_pc      = (32'($urandom_range(0, 3)) << (IDX + 2)) | (32'($urandom_range(0, 31)) << 2);
      if_advance = 1'($urandom_range(0, 1));
      upd_valid  = ($urandom_range(0, 2) != 0);
      upd_pc     = ($urandom_range(0, 3) == 0) ? if_pc :
                   (32'($urandom_range(0, 3)) << (IDX + 2)) | (32'($urandom_range(0, 31)) << 2);
      upd_taken  = 1'($urandom_range(0, 1));
      upd_target = $urandom & 32'hffff_fffc;
      upd_ghr    = GHR_BITS'($urandom);
      upd_mispredict = ($urandom_range(0, 3) == 0);
      #1;
      li   = idx_of(if_pc);
      eh   = m_valid[li] && (m_tag[li] == tag_of(if_pc));
      et   = eh && (m_pht[li ^ m_ghr] >= CTR_MID);
      etgt = et ? m_tgt[li] : if_pc + 32'd4;
      check($sformatf("rand[%0d]", c), 64'({pred_hit, pred_taken, pred_target, pred_ghr}),
            64'({eh, et, etgt, GHR_BITS'(m_ghr)}));
      if (upd_valid) begin
        ui = idx_of(upd_pc);
        pi = ui ^ 32'(upd_ghr);
        if (upd_taken) begin
          if (m_pht[pi] < CTR_TOP) m_pht[pi]++;
          m_valid[ui] = 1; m_tag[ui] = tag_of(upd_pc); m_tgt[ui] = upd_target;
        end else if (m_pht[pi] > 0) begin
          m_pht[pi]--;
        end
      end
      if (upd_valid && upd_mispredict) begin
        m_ghr = (32'(upd_ghr) * 2 + 32'(upd_taken)) % (1 << GHR_BITS);
      end else if (if_advance && eh) begin
        m_ghr = (m_ghr * 2 + 32'(et)) % (1 << GHR_BITS);
      end
    end
  endtask

  // ---------------- test ----------------
  vec_t tbl[$];

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Lookup 0x100: index 0, tag 2.  Lookup 0x140: index 16, tag 2.
    //         pc        adv uv  upc       ut  utgt      ughr  um  eh  et  etgt      eghr
    tbl.push_back(mk(32'h100, 0, 0, 32'h0,   0, 32'h0,   5'd0, 0,  0,  0, 32'h104, 5'd0));
    tbl.push_back(mk(32'h100, 0, 1, 32'h100, 1, 32'h200, 5'd0, 0,  0,  0, 32'h104, 5'd0));
    tbl.push_back(mk(32'h100, 0, 1, 32'h100, 1, 32'h200, 5'd0, 0,  1,  1, 32'h200, 5'd0));
    tbl.push_back(mk(32'h100, 0, 0, 32'h0,   0, 32'h0,   5'd0, 0,  1,  1, 32'h200, 5'd0));
    tbl.push_back(mk(32'h140, 0, 1, 32'h140, 1, 32'h300, 5'd0, 0,  0,  0, 32'h144, 5'd0));
    tbl.push_back(mk(32'h140, 0, 0, 32'h0,   0, 32'h0,   5'd0, 0,  1,  1, 32'h300, 5'd0));
    // Four not-taken on counter 2: 1, 0, 0, 0; one taken -> 1 (a wrap would read as taken).
    tbl.push_back(mk(32'h140, 0, 1, 32'h140, 0, 32'h0,   5'd0, 0,  1,  1, 32'h300, 5'd0));
    tbl.push_back(mk(32'h140, 0, 1, 32'h140, 0, 32'h0,   5'd0, 0,  1,  0, 32'h144, 5'd0));
    tbl.push_back(mk(32'h140, 0, 1, 32'h140, 0, 32'h0,   5'd0, 0,  1,  0, 32'h144, 5'd0));
    tbl.push_back(mk(32'h140, 0, 1, 32'h140, 0, 32'h0,   5'd0, 0,  1,  0, 32'h144, 5'd0));
    tbl.push_back(mk(32'h140, 0, 1, 32'h140, 1, 32'h300, 5'd0, 0,  1,  0, 32'h144, 5'd0));
    tbl.push_back(mk(32'h140, 0, 0, 32'h0,   0, 32'h0,   5'd0, 0,  1,  0, 32'h144, 5'd0));
    // Four taken from 1: 2, 3, 3, 3; one not-taken -> 2, still taken.
    tbl.push_back(mk(32'h140, 0, 1, 32'h140, 1, 32'h300, 5'd0, 0,  1,  0, 32'h144, 5'd0));
    tbl.push_back(mk(32'h140, 0, 1, 32'h140, 1, 32'h300, 5'd0, 0,  1,  1, 32'h300, 5'd0));
    tbl.push_back(mk(32'h140, 0, 1, 32'h140, 1, 32'h300, 5'd0, 0,  1,  1, 32'h300, 5'd0));
    tbl.push_back(mk(32'h140, 0, 1, 32'h140, 1, 32'h300, 5'd0, 0,  1,  1, 32'h300, 5'd0));
    tbl.push_back(mk(32'h140, 0, 1, 32'h140, 0, 32'h0,   5'd0, 0,  1,  1, 32'h300, 5'd0));
    tbl.push_back(mk(32'h140, 0, 0, 32'h0,   0, 32'h0,   5'd0, 0,  1,  1, 32'h300, 5'd0));

    // Outputs while reset is held.
    #2;
    if_pc = 32'h100;
    #1;
    check("in_reset", 64'({pred_hit, pred_taken, pred_target, pred_ghr}),
          64'({1'b0, 1'b0, 32'h104, 5'd0}));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Train PHT[0 ^ 22] to strongly taken, then repair GHR to 0b10110.
    apply(mk(32'h100, 0, 1, 32'h100, 1, 32'h200, 5'd22, 0, 1, 1, 32'h200, 5'd0), "train0");
    apply(mk(32'h100, 0, 1, 32'h100, 1, 32'h200, 5'd22, 0, 1, 1, 32'h200, 5'd0), "train1");
    apply(mk(32'h100, 0, 1, 32'h800, 0, 32'h0, 5'd11, 1, 1, 1, 32'h200, 5'd0), "set_ghr");
    // Predicted-taken advance collides with a repair: repair wins -> 0b00110.
    apply(mk(32'h100, 1, 1, 32'h800, 0, 32'h0, 5'd3, 1, 1, 1, 32'h200, 5'd22), "repair_vs_spec");
    // Speculative shift of a not-taken prediction: 0b00110 -> 0b01100.
    apply(mk(32'h100, 1, 0, 32'h0, 0, 32'h0, 5'd0, 0, 1, 0, 32'h104, 5'd6), "spec_shift");
    apply(mk(32'h100, 0, 0, 32'h0, 0, 32'h0, 5'd0, 0, 1, 0, 32'h104, 5'd12), "after_shift");
    apply(mk(32'h100, 0, 0, 32'h0, 0, 32'h0, 5'd0, 0, 1, 0, 32'h104, 5'd12), "stall_hold");

    // Asynchronous reset mid-cycle with an update pending at 0x144.
    @(negedge clk);
    drive(mk(32'h100, 1, 1, 32'h144, 1, 32'h500, 5'd0, 0, 0, 0, 32'h0, 5'd0));
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", 64'({pred_hit, pred_taken, pred_target, pred_ghr}),
          64'({1'b0, 1'b0, 32'h104, 5'd0}));
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    apply(mk(32'h144, 0, 0, 32'h0, 0, 32'h0, 5'd0, 0, 0, 0, 32'h148, 5'd0), "upd_ignored");
    apply(mk(32'h140, 0, 0, 32'h0, 0, 32'h0, 5'd0, 0, 0, 0, 32'h144, 5'd0), "btb_cleared");
    // Cold PHT[0] = 1: one taken -> 2 (taken), one not-taken -> 1 (not taken).
    apply(mk(32'h100, 0, 1, 32'h100, 1, 32'h200, 5'd0, 0, 0, 0, 32'h104, 5'd0), "cold0");
    apply(mk(32'h100, 0, 1, 32'h100, 0, 32'h0, 5'd0, 0, 1, 1, 32'h200, 5'd0), "cold1");
    apply(mk(32'h100, 0, 0, 32'h0, 0, 32'h0, 5'd0, 0, 1, 0, 32'h104, 5'd0), "cold2");

    do_reset();
    model_reset();
    run_random(600);

`ifdef BP_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_pc = 32'h100; if_advance = 1'b1;
      upd_valid = (i % 3 == 1); upd_mispredict = (i % 3 == 1);
      upd_pc = 32'h800; upd_taken = 1'b0; upd_ghr = '0;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("perf_lookups", 64'(perf_lookups), 64'd10);
    check("perf_mispredicts", 64'(perf_mispredicts), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    check("perf_reset", 64'({perf_lookups, perf_mispredicts}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
